// File: rtl/data_write_buffer.sv
// Write buffer: FWFT FIFO of packed words drained to memory as address+data bursts of up to MAX_BURST beats.
// Optional overflow detection is built when WRITE_BUFFER_OVF_CHECK_EN is defined.
module data_write_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_write_req,
  output logic                  s_write_ready,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_wr_addr_req,
  input  logic                  mem_wr_addr_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [LEN_WIDTH-1:0]  mem_wr_len,
  output logic                  mem_wr_data_valid,
  input  logic                  mem_wr_data_ready,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_last,
  output logic                  err_overflow,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid/req and ready are both high;
  // the source holds its payload stable while waiting for ready.

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  blen;
  logic                  last_beat;
  logic                  addr_hs, data_hs;

  assign push    = s_write_req && s_write_ready;
  assign pop     = data_hs;
  assign addr_hs = mem_wr_addr_req && mem_wr_addr_ready;
  assign data_hs = mem_wr_data_valid && mem_wr_data_ready;

  assign s_write_ready = (count != CW'(FIFO_DEPTH));
  assign mem_wr_data   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WRITE_BUFFER_OVF_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_overflow <= 1'b0;
    else if (s_write_req && !s_write_ready) err_overflow <= 1'b1;
  end
`else
  assign err_overflow = 1'b0;
`endif

  assign blen      = (remaining_q < LEN_WIDTH'(MAX_BURST)) ? remaining_q : LEN_WIDTH'(MAX_BURST);
  assign last_beat = (beat_q == blen - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cfg_start) state_nxt = (cfg_num_words == '0) ? S_DONE : S_WAIT;
      S_WAIT: if (LEN_WIDTH'(count) >= blen) state_nxt = S_ADDR;
      S_ADDR: if (addr_hs) state_nxt = S_DATA;
      S_DATA: if (data_hs && last_beat) state_nxt = (remaining_q == blen) ? S_DONE : S_WAIT;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job bookkeeping: address and remaining count advance only once a whole burst has drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
    end else begin
      if (state == S_IDLE && cfg_start) begin
        addr_q      <= cfg_base_addr;
        remaining_q <= cfg_num_words;
      end
      if (addr_hs) beat_q <= '0;
      if (data_hs) begin
        beat_q <= beat_q + LEN_WIDTH'(1);
        if (last_beat) begin
          remaining_q <= remaining_q - blen;
          addr_q      <= addr_q + ADDR_WIDTH'(blen) * ADDR_WIDTH'(BYTES);
        end
      end
    end
  end

  always_comb begin
    busy              = (state != S_IDLE);
    done              = 1'b0;
    mem_wr_addr_req   = 1'b0;
    mem_wr_addr       = '0;
    mem_wr_len        = '0;
    mem_wr_data_valid = 1'b0;
    mem_wr_last       = 1'b0;
    case (state)
      S_ADDR: begin
        mem_wr_addr_req = 1'b1;
        mem_wr_addr     = addr_q;
        mem_wr_len      = blen - LEN_WIDTH'(1);
      end
      S_DATA: begin
        mem_wr_data_valid = 1'b1;
        mem_wr_last       = last_beat;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_data_write_buffer.sv
// Scoreboard bench for data_write_buffer: random words and jobs, a queue model of FIFO contents
// and an arithmetic burst plan, compared by a negedge monitor.
module tb_data_write_buffer;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int FD = 32;
  localparam int MB = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_write_req;
  logic          s_write_ready;
  logic [DW-1:0] s_write_data;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [LW-1:0] cfg_num_words;
  logic          busy, done;
  logic          mem_wr_addr_req, mem_wr_addr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [LW-1:0] mem_wr_len;
  logic          mem_wr_data_valid, mem_wr_data_ready;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_last;
  logic          err_overflow;
  logic [2:0]    dbg_state;

  data_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .MAX_BURST(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .s_write_req(s_write_req), .s_write_ready(s_write_ready), .s_write_data(s_write_data),
    .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr), .cfg_num_words(cfg_num_words),
    .busy(busy), .done(done),
    .mem_wr_addr_req(mem_wr_addr_req), .mem_wr_addr_ready(mem_wr_addr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_len(mem_wr_len),
    .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_data_ready(mem_wr_data_ready),
    .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
    .err_overflow(err_overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents, planned bursts {addr, len-1}, job progress
  logic [DW-1:0]    exp_q[$];
  logic [AW+LW-1:0] burst_q[$];
  bit               job_active = 0;
  bit               done_exp = 0;
  bit               ovf_exp = 0;
  int               beats_left = 0;
  int               cur_len = 0;
  int               beat_idx = 0;
  int               done_count = 0;
  int               data_hs_count = 0;
  bit               bp_en = 0;

  bit               addr_stall = 0, data_stall = 0;
  logic [AW-1:0]    st_addr;
  logic [LW-1:0]    st_len;
  logic [DW-1:0]    st_data;
  logic             st_last;

  always @(negedge clk) begin
    bit model_ready;
    bit next_done;
    logic [AW+LW-1:0] b;
    logic [DW-1:0] w;
    if (reset) begin
      check("rst_ready", s_write_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr_req", mem_wr_addr_req, 0);
      check("rst_addr", mem_wr_addr, 0);
      check("rst_len", mem_wr_len, 0);
      check("rst_data_valid", mem_wr_data_valid, 0);
      check("rst_data", mem_wr_data, 0);
      check("rst_last", mem_wr_last, 0);
      check("rst_overflow", err_overflow, 0);
      exp_q.delete();
      burst_q.delete();
      job_active = 0; done_exp = 0; ovf_exp = 0; beats_left = 0;
      addr_stall = 0; data_stall = 0;
    end else begin
      model_ready = (exp_q.size() < FD);
      next_done = 0;
      check("s_write_ready", s_write_ready, model_ready);
      check("busy", busy, job_active);
      check("done", done, done_exp);
      check("err_overflow", err_overflow, ovf_exp);
      if (addr_stall) begin
        check("addr_req_held", mem_wr_addr_req, 1);
        check("addr_held", mem_wr_addr, st_addr);
        check("len_held", mem_wr_len, st_len);
      end
      if (data_stall) begin
        check("data_valid_held", mem_wr_data_valid, 1);
        check("data_held", mem_wr_data, st_data);
        check("last_held", mem_wr_last, st_last);
      end
      if (mem_wr_addr_req && mem_wr_addr_ready) begin
        check("addr_expected", burst_q.size() != 0, 1);
        if (burst_q.size() != 0) begin
          b = burst_q.pop_front();
          check("burst_addr", mem_wr_addr, b[AW+LW-1:LW]);
          check("burst_len", mem_wr_len, b[LW-1:0]);
          cur_len = int'(b[LW-1:0]);
          beat_idx = 0;
        end
      end
      addr_stall = mem_wr_addr_req && !mem_wr_addr_ready;
      st_addr = mem_wr_addr; st_len = mem_wr_len;
      if (mem_wr_data_valid && mem_wr_data_ready) begin
        check("data_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("beat_data", mem_wr_data, w);
          check("beat_last", mem_wr_last, beat_idx == cur_len);
          beat_idx++;
          beats_left--;
          data_hs_count++;
          if (beats_left == 0) next_done = 1;
        end
      end
      data_stall = mem_wr_data_valid && !mem_wr_data_ready;
      st_data = mem_wr_data; st_last = mem_wr_last;
      if (s_write_req) begin
        if (model_ready) exp_q.push_back(s_write_data);
`ifdef WRITE_BUFFER_OVF_CHECK_EN
        else ovf_exp = 1;
`endif
      end
      if (cfg_start && !job_active) begin
        job_active = 1;
        beats_left = int'(cfg_num_words);
        if (cfg_num_words == 0) next_done = 1;
        for (int off = 0; off < int'(cfg_num_words); off += MB) begin
          int l;
          logic [AW-1:0] a;
          l = (int'(cfg_num_words) - off < MB) ? int'(cfg_num_words) - off : MB;
          a = cfg_base_addr + AW'(off * (DW / 8));
          burst_q.push_back({a, LW'(l - 1)});
        end
      end
      if (done_exp) begin
        done_count++;
        job_active = 0;
      end
      done_exp = next_done;
    end
  end

  // Memory-side ready generation
  initial begin
    mem_wr_addr_ready = 1'b1;
    mem_wr_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        mem_wr_addr_ready = ($urandom_range(1) == 1);
        mem_wr_data_ready = ($urandom_range(3) != 0);
      end else begin
        mem_wr_addr_ready = 1'b1;
        mem_wr_data_ready = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_job(input logic [AW-1:0] base, input int n);
    tick();
    cfg_start = 1'b1;
    cfg_base_addr = base;
    cfg_num_words = LW'(n);
    tick();
    cfg_start = 1'b0;
    cfg_base_addr = $urandom;
    cfg_num_words = LW'($urandom);
  endtask

  // Offers words only when the model has room, so every offer is accepted
  task automatic feed(input int n, input int gap_pct);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 5000) begin
      if ($urandom_range(99) >= gap_pct && exp_q.size() < FD) begin
        s_write_req = 1'b1;
        s_write_data = rand_word();
        acc++;
      end else begin
        s_write_req = 1'b0;
      end
      tick();
      cyc++;
    end
    s_write_req = 1'b0;
    check("feed_timeout", acc, n);
  endtask

  task automatic flood(input int n);
    for (int i = 0; i < n; i++) begin
      s_write_req = 1'b1;
      s_write_data = rand_word();
      tick();
    end
    s_write_req = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start_cnt = done_count;
    int cyc = 0;
    while (done_count == start_cnt && cyc < bound) begin
      tick();
      cyc++;
    end
    check("done_timeout", done_count != start_cnt, 1);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_tgt;
    reset = 1'b1;
    s_write_req = 1'b0;
    s_write_data = '0;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_num_words = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Single full burst from preloaded data
    feed(16, 0);
    start_job(32'h0000_1000, 16);
    wait_done(200);

    // 40 words: two full bursts and a partial one
    start_job(32'h0, 40);
    fork
      feed(40, 20);
      wait_done(2000);
    join

    // Empty job
    start_job(32'h40, 0);
    wait_done(10);

    // Fill to full, keep offering (drop/overflow), drain with backpressure
    flood(40);
    bp_en = 1;
    start_job($urandom, 32);
    wait_done(2000);
    bp_en = 0;

    // Random jobs, one wrapping the address space
    for (int j = 0; j < 6; j++) begin
      int n = $urandom_range(1, 60);
      logic [AW-1:0] base = (j == 2) ? 32'hFFFF_FF00 : $urandom;
      bp_en = ($urandom_range(1) == 1);
      start_job(base, n);
      fork
        feed(n, 30);
        wait_done(4000);
      join
    end
    bp_en = 0;

    // Reset in the middle of a burst with 5 beats outstanding
    feed(16, 0);
    base_tgt = data_hs_count + 11;
    start_job(32'h0000_2000, 16);
    for (int c = 0; c < 200 && data_hs_count < base_tgt; c++) tick();
    check("reset_reach_data", data_hs_count >= base_tgt, 1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // Recovery after reset
    start_job(32'h0000_3000, 5);
    fork
      feed(5, 10);
      wait_done(500);
    join

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_write_buffer.md
# data_write_buffer

Downstream consumer of the wide-word packer: accepts packed OUT_WIDTH words on the packer's req/ready handshake, stores them in an internal FIFO, and drains them to external memory as address-plus-data write bursts. A single configured job streams `cfg_num_words` words starting at `cfg_base_addr`, split into bursts of at most MAX_BURST beats, then pulses `done`.

## Interface
- DATA_WIDTH, 128, width of one packed word (equals the packer's OUT_WIDTH).
- ADDR_WIDTH, 32, byte address width.
- FIFO_DEPTH, 32, buffer entries; power of 2, at least MAX_BURST.
- MAX_BURST, 16, maximum beats per burst; power of 2.
- LEN_WIDTH, 16, width of the word-count fields.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_write_req  in  1  packed word valid (from the packer's m_write_req).
- s_write_ready  out  1  FIFO not full.
- s_write_data  in  DATA_WIDTH  packed word.
- cfg_start  in  1  single-cycle job start pulse; sampled only in IDLE.
- cfg_base_addr  in  ADDR_WIDTH  byte address of the first word.
- cfg_num_words  in  LEN_WIDTH  number of words in the job.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- mem_wr_addr_req  out  1  burst address valid.
- mem_wr_addr_ready  in  1  burst address accepted.
- mem_wr_addr  out  ADDR_WIDTH  burst byte address.
- mem_wr_len  out  LEN_WIDTH  burst beats minus 1.
- mem_wr_data_valid  out  1  data beat valid.
- mem_wr_data_ready  in  1  data beat accepted.
- mem_wr_data  out  DATA_WIDTH  data beat, taken from the FIFO head.
- mem_wr_last  out  1  marks the final beat of a burst.
- err_overflow  out  1  sticky overflow flag (see Configuration).

## Operation
- FIFO:
  - First-word-fall-through; `mem_wr_data` always shows the head entry.
  - Push when `s_write_req && s_write_ready`; pop on a data-beat handshake.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pushes are accepted in any state, including IDLE, so data may arrive before `cfg_start`.
- FSM states: IDLE, WAIT, ADDR, DATA, DONE.
  - **IDLE:** on `cfg_start`, latch `addr = cfg_base_addr` and `remaining = cfg_num_words`. Go to DONE if `cfg_num_words == 0`, otherwise to WAIT.
  - **WAIT:** compute `blen = min(remaining, MAX_BURST)`. Go to ADDR once the FIFO count is at least `blen`.
  - **ADDR:** drive `mem_wr_addr_req = 1`, `mem_wr_addr = addr`, `mem_wr_len = blen - 1`, all held stable until `mem_wr_addr_ready`. Then go to DATA with the beat counter cleared.
  - **DATA:**
    - `mem_wr_data_valid = 1` (the FIFO is guaranteed non-empty).
    - `mem_wr_last` is high when `beat == blen - 1`.
    - On each handshake, increment `beat` and pop the FIFO.
    - After the last-beat handshake: `remaining -= blen` and `addr += blen * DATA_WIDTH/8`, then go to DONE if `remaining == 0`, else to WAIT.
  - **DONE:** `done = 1` for one cycle, then IDLE.
- `cfg_start` outside IDLE is ignored. Config inputs are not sampled after the IDLE→WAIT transition.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No boundary splitting is performed.

## Timing
- Reset values:
  - FSM in IDLE, FIFO empty.
  - `s_write_ready = 1`.
  - All other outputs 0, including `mem_wr_addr`, `mem_wr_len`, and `err_overflow`.
- Reset asserted mid-job aborts the job and discards the FIFO contents. No `done` is produced.
- `s_write_ready` is registered-count based. A full FIFO deasserts it in the cycle after the filling push.
- Job start latency:
  - `cfg_start` seen at edge N puts the FSM in WAIT from N+1.
  - If the FIFO count is already at least `blen`, `mem_wr_addr_req` is high from N+2.
- The first data beat is valid in the cycle after the address handshake.
- Beats stream back to back, one per cycle, while `mem_wr_data_ready` is high.
- `done` is high in the cycle after the final data handshake of the job.

## Configuration
- `WRITE_BUFFER_OVF_CHECK_EN` defined:
  - `s_write_req` while `s_write_ready == 0` sets `err_overflow`, which stays set until reset.
  - The offered word is dropped.
- Macro undefined:
  - No checking logic is built and `err_overflow` is tied to 0.
  - A word offered while full is silently dropped.

## Test plan
- Preload 16 words, start with base 0x1000, 16 words → one burst with addr 0x1000, len 15, 16 beats, `mem_wr_last` on beat 16, `done` one cycle later.
- 40 words, base 0x0 → bursts at 0x000/len15, 0x100/len15, 0x200/len7 (byte offset 16 × 16 per full burst); exactly 40 pops; FIFO empty at `done`.
- `cfg_num_words = 0` → `done` 2 cycles after start, no `mem_wr_addr_req`.
- Random backpressure on `mem_wr_addr_ready`/`mem_wr_data_ready` with the FIFO filled to 32 → `s_write_ready = 0` while full; address/len/data held stable while not ready; data order preserved.
- Push while full with the macro defined → `err_overflow = 1` (sticky) and the word is dropped; with the macro undefined → flag stays 0.
- Assert `reset` during DATA with 5 beats pending → all outputs return to 0, FIFO empty, state IDLE, no `done`.
